// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the register-group access controller:
// command opcodes, register-group address codes and the FSM state type.
package reg_ctrl_pkg;

  // Command opcodes carried on cmd_op
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_MOVE = 2'b11;

  // Register-group addresses; NULL reads as zero and ignores writes
  localparam logic [1:0] ADDR_A    = 2'b00;
  localparam logic [1:0] ADDR_B    = 2'b01;
  localparam logic [1:0] ADDR_NULL = 2'b10;
  localparam logic [1:0] ADDR_C    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_t;

endpackage

// File: rtl/reg_group_ctrl.sv
// Command-driven access controller for the A/B/C register group.
// Accepts NOP/LOAD/READ/MOVE commands, drives the group's registered
// address/data lines and active-low write strobe, and returns read data.
// Optional feature macro: REG_ACCESS_GUARD_EN -- when defined, LOAD/MOVE
// targeting the null address skip the write and flag rsp_err.
module reg_group_ctrl
  import reg_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_rs,
  input  logic [1:0] cmd_rd,
  input  logic [7:0] cmd_imm,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_s,
  output logic [7:0] rsp_d,
  output logic       rsp_err,
  output logic       rg_we,
  output logic [1:0] rg_raa,
  output logic [1:0] rg_rwba,
  output logic [7:0] rg_i,
  input  logic [7:0] rg_s,
  input  logic [7:0] rg_d
);

`ifdef REG_ACCESS_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  state_t     state_q, state_n;
  logic [1:0] op_q, op_n;
  logic [1:0] rd_q, rd_n;
  logic       we_q, we_n;
  logic [1:0] raa_q, raa_n;
  logic [1:0] rwba_q, rwba_n;
  logic [7:0] i_q, i_n;
  logic [7:0] rsp_s_q, rsp_s_n;
  logic [7:0] rsp_d_q, rsp_d_n;
  logic       err_q, err_n;

  // Next-state and next-output decode; rg_* values are computed one cycle
  // ahead so the registered copies are stable for the whole RD/WR cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    state_n = state_q;
    op_n    = op_q;
    rd_n    = rd_q;
    we_n    = 1'b1;
    raa_n   = ADDR_NULL;
    rwba_n  = ADDR_NULL;
    i_n     = '0;
    rsp_s_n = rsp_s_q;
    rsp_d_n = rsp_d_q;
    err_n   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_n  = cmd_op;
          rd_n  = cmd_rd;
          err_n = 1'b0;
          unique case (cmd_op)
            OP_NOP: begin
              state_n = ST_RESP;
              rsp_s_n = '0;
              rsp_d_n = '0;
            end
            OP_READ: begin
              state_n = ST_RD;
              raa_n   = cmd_rs;
              rwba_n  = cmd_rd;
            end
            OP_LOAD: begin
              rsp_s_n = '0;
              if (GUARD_EN && cmd_rd == ADDR_NULL) begin
                state_n = ST_RESP;
                rsp_d_n = '0;
                err_n   = 1'b1;
              end else begin
                state_n = ST_WR;
                rwba_n  = cmd_rd;
                i_n     = cmd_imm;
                we_n    = 1'b0;
                rsp_d_n = cmd_imm;
              end
            end
            default: begin // OP_MOVE: fetch the source first
              state_n = ST_RD;
              raa_n   = cmd_rs;
            end
          endcase
        end
      end

      ST_RD: begin
        rsp_s_n = rg_s;
        if (op_q == OP_MOVE) begin
          if (GUARD_EN && rd_q == ADDR_NULL) begin
            state_n = ST_RESP;
            rsp_d_n = '0;
            err_n   = 1'b1;
          end else begin
            state_n = ST_WR;
            rwba_n  = rd_q;
            i_n     = rg_s;
            we_n    = 1'b0;
            rsp_d_n = rg_s;
          end
        end else begin
          state_n = ST_RESP;
          rsp_d_n = rg_d;
        end
      end

      ST_WR: state_n = ST_RESP;

      default: begin // ST_RESP: hold until the consumer takes it
        if (rsp_ready) state_n = ST_IDLE;
      end
    endcase
  end

  // State and registered output update with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      rd_q    <= ADDR_NULL;
      we_q    <= 1'b1;
      raa_q   <= ADDR_NULL;
      rwba_q  <= ADDR_NULL;
      i_q     <= '0;
      rsp_s_q <= '0;
      rsp_d_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      op_q    <= op_n;
      rd_q    <= rd_n;
      we_q    <= we_n;
      raa_q   <= raa_n;
      rwba_q  <= rwba_n;
      i_q     <= i_n;
      rsp_s_q <= rsp_s_n;
      rsp_d_q <= rsp_d_n;
      err_q   <= err_n;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE) && rst_n;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_s     = rsp_s_q;
  assign rsp_d     = rsp_d_q;
  assign rsp_err   = err_q;
  assign rg_we     = we_q;
  assign rg_raa    = raa_q;
  assign rg_rwba   = rwba_q;
  assign rg_i      = i_q;

endmodule

// File: tb/tb_reg_group_ctrl.sv
// Self-checking bench for reg_group_ctrl. Models the A/B/C register group
// (falling-edge write, null address reads zero) and predicts every response
// from a simple array-based model of the command semantics.
module tb_reg_group_ctrl;

`ifdef REG_ACCESS_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op, cmd_rs, cmd_rd;
  logic [7:0] cmd_imm;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_s, rsp_d;
  logic       rsp_err;
  logic       rg_we;
  logic [1:0] rg_raa, rg_rwba;
  logic [7:0] rg_i, rg_s, rg_d;

  logic [7:0] grp[4];
  logic [7:0] mdl[4];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  reg_group_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_d(rsp_d), .rsp_err(rsp_err),
    .rg_we(rg_we), .rg_raa(rg_raa), .rg_rwba(rg_rwba), .rg_i(rg_i),
    .rg_s(rg_s), .rg_d(rg_d)
  );

  // Register group: writes on the falling edge, null address reads zero
  always @(negedge clk) begin
    if (rg_we === 1'b0 && rg_rwba != 2'b10) grp[rg_rwba] <= rg_i;
  end
  assign rg_s = (rg_raa  == 2'b10) ? 8'h00 : grp[rg_raa];
  assign rg_d = (rg_rwba == 2'b10) ? 8'h00 : grp[rg_rwba];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mread(input logic [1:0] a);
    return (a == 2'b10) ? 8'h00 : mdl[a];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " cmd_ready"}, cmd_ready, 0);
    check({tag, " rsp_valid"}, rsp_valid, 0);
    check({tag, " rsp_s"}, rsp_s, 0);
    check({tag, " rsp_d"}, rsp_d, 0);
    check({tag, " rsp_err"}, rsp_err, 0);
    check({tag, " rg_we"}, rg_we, 1);
    check({tag, " rg_raa"}, rg_raa, 2'b10);
    check({tag, " rg_rwba"}, rg_rwba, 2'b10);
    check({tag, " rg_i"}, rg_i, 0);
  endtask

  // Issue one command starting at a negedge, wait for the response, hold
  // rsp_ready low for 'hold' cycles, then complete the handshake.
  task automatic do_cmd(input logic [1:0] op, input logic [1:0] rs, input logic [1:0] rd,
                        input logic [7:0] imm, input int hold);
    logic [7:0] es, ed, wdata;
    logic       ee, wr;
    int         elat, lat, we_cnt;
    es = 0; ed = 0; ee = 0; wr = 0; wdata = 0; elat = 1;
    case (op)
      2'b00: elat = 1;
      2'b10: begin es = mread(rs); ed = mread(rd); elat = 2; end
      2'b01: begin wdata = imm; ed = imm; elat = 2; wr = 1; end
      default: begin wdata = mread(rs); es = wdata; ed = wdata; elat = 3; wr = 1; end
    endcase
    if (GUARD && wr && rd == 2'b10) begin
      ee = 1; ed = 0; wr = 0; elat = elat - 1;
    end

    check("ready before cmd", cmd_ready, 1);
    cmd_valid = 1; cmd_op = op; cmd_rs = rs; cmd_rd = rd; cmd_imm = imm;
    @(negedge clk);
    cmd_valid = 0; cmd_op = 0; cmd_rs = 0; cmd_rd = 0; cmd_imm = 0;
    lat = 1; we_cnt = 0;
    while (!rsp_valid && lat < 8) begin
      check("ready while busy", cmd_ready, 0);
      if (!rg_we) begin
        we_cnt++;
        check("write addr", rg_rwba, rd);
        check("write data", rg_i, wdata);
      end
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      check("rsp timeout", 0, 1);
      return;
    end
    check("latency", lat, elat);
    check("we pulses", we_cnt, wr ? 1 : 0);
    check("rsp_s", rsp_s, es);
    check("rsp_d", rsp_d, ed);
    check("rsp_err", rsp_err, ee);

    for (int k = 0; k < hold; k++) begin
      cmd_valid = 1; cmd_op = 2'b00;
      @(negedge clk);
      check("hold valid", rsp_valid, 1);
      check("hold ready", cmd_ready, 0);
      check("hold rsp_s", rsp_s, es);
      check("hold rsp_d", rsp_d, ed);
      check("hold we", rg_we, 1);
    end
    cmd_valid = 0;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("valid after handshake", rsp_valid, 0);

    if (wr && rd != 2'b10) mdl[rd] = wdata;
    check("reg A", grp[0], mdl[0]);
    check("reg B", grp[1], mdl[1]);
    check("reg C", grp[3], mdl[3]);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin grp[i] = 8'h00; mdl[i] = 8'h00; end
    rst_n = 0; cmd_valid = 0; cmd_op = 0; cmd_rs = 0; cmd_rd = 0; cmd_imm = 0;
    rsp_ready = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1;
    @(negedge clk);

    // Directed scenarios
    do_cmd(2'b01, 2'b00, 2'b00, 8'h5A, 0);   // LOAD A=5A
    do_cmd(2'b10, 2'b00, 2'b00, 8'h00, 1);   // READ A
    do_cmd(2'b01, 2'b00, 2'b01, 8'h0B, 0);   // LOAD B=0B
    do_cmd(2'b01, 2'b00, 2'b11, 8'hC0, 0);   // LOAD C=C0
    do_cmd(2'b10, 2'b01, 2'b11, 8'h00, 0);   // READ rs=B rd=C
    do_cmd(2'b11, 2'b11, 2'b00, 8'h00, 0);   // MOVE C -> A
    do_cmd(2'b10, 2'b00, 2'b10, 8'h00, 5);   // READ with stalled consumer
    do_cmd(2'b01, 2'b00, 2'b10, 8'hFF, 0);   // LOAD to null
    do_cmd(2'b11, 2'b01, 2'b10, 8'h00, 2);   // MOVE to null
    do_cmd(2'b00, 2'b01, 2'b11, 8'h77, 0);   // NOP

    // Reset lands on the edge that ends the WR cycle of LOAD B=33
    cmd_valid = 1; cmd_op = 2'b01; cmd_rs = 0; cmd_rd = 2'b01; cmd_imm = 8'h33;
    @(negedge clk);
    cmd_valid = 0;
    check("mid-reset in WR", rg_we, 0);
    rst_n = 0;
    @(negedge clk);
    check_reset_outputs("mid reset");
    mdl[1] = 8'h33;
    check("reg B after reset", grp[1], mdl[1]);
    rst_n = 1;
    @(negedge clk);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      do_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
